// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - front-panel key sequencer and alarm ring scheduler for the 24h clock
//
// Optional feature macro: CLK_SNOOZE_EN (adds snooze on key_adj while ringing).
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   tick_1hz            one-clk strobe on the datapath's 1 Hz update edge
//   key_mode/adj/stop   debounced key levels, high = pressed
//   count, count_alarm  current time and alarm time, seconds since midnight
//   hour_change,
//   minute_change,
//   alarm_en            datapath adjust controls
//   setting             high in any state other than RUN
//   ring                alarm sounding
//   state               FSM state code for display blinking
module clock_set_ctrl #(
  parameter int IDLE_SEC   = 10,
  parameter int RING_SEC   = 60
`ifdef CLK_SNOOZE_EN
  ,
  parameter int SNOOZE_SEC = 300
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic        key_mode,
  input  logic        key_adj,
  input  logic        key_stop,
  input  logic [20:0] count,
  input  logic [20:0] count_alarm,
  output logic        hour_change,
  output logic        minute_change,
  output logic        alarm_en,
  output logic        setting,
  output logic        ring,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_AL_HOUR  = 3'd3,
    ST_AL_MIN   = 3'd4
  } state_t;

  localparam int IW = $clog2(IDLE_SEC + 1);
  localparam int RW = $clog2(RING_SEC + 1);

  state_t          r_state, w_next;
  logic            r_mode_q, r_adj_q, r_stop_q;
  logic            w_mode_e, w_adj_e, w_stop_e, w_idle_to, w_ring_start;
  logic [IW-1:0]   r_idle_cnt;
  logic [RW-1:0]   r_ring_cnt;
  logic            r_hc, r_mc, r_ae, r_setting, r_ring;
  logic            w_hc, w_mc, w_ae;

  // Edge registers reset to 1 so a key held through reset gives no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= 1'b1;
      r_adj_q  <= 1'b1;
      r_stop_q <= 1'b1;
    end else begin
      r_mode_q <= key_mode;
      r_adj_q  <= key_adj;
      r_stop_q <= key_stop;
    end
  end

  assign w_mode_e  = key_mode & ~r_mode_q;
  assign w_adj_e   = key_adj  & ~r_adj_q;
  assign w_stop_e  = key_stop & ~r_stop_q;
  assign w_idle_to = tick_1hz && (r_idle_cnt == IW'(IDLE_SEC - 1));
  assign w_ring_start = (r_state == ST_RUN) && tick_1hz && (count == count_alarm) && !r_ring;

  // Next state: a mode edge always wins over the idle timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN:      if (w_mode_e) w_next = ST_SET_HOUR;
      ST_SET_HOUR: if (w_mode_e) w_next = ST_SET_MIN;  else if (w_idle_to) w_next = ST_RUN;
      ST_SET_MIN:  if (w_mode_e) w_next = ST_AL_HOUR;  else if (w_idle_to) w_next = ST_RUN;
      ST_AL_HOUR:  if (w_mode_e) w_next = ST_AL_MIN;   else if (w_idle_to) w_next = ST_RUN;
      ST_AL_MIN:   if (w_mode_e) w_next = ST_RUN;      else if (w_idle_to) w_next = ST_RUN;
      default:     w_next = ST_RUN;
    endcase
  end

  // Datapath controls for the state being entered; 11 means hold.
  always_comb begin
    w_hc = 1'b1;
    w_mc = 1'b1;
    w_ae = 1'b0;
    case (w_next)
      ST_RUN:      begin w_hc = 1'b0; w_mc = 1'b0; end
      ST_SET_HOUR: w_mc = !key_adj;
      ST_SET_MIN:  w_hc = !key_adj;
      ST_AL_HOUR:  begin w_mc = !key_adj; w_ae = 1'b1; end
      ST_AL_MIN:   begin w_hc = !key_adj; w_ae = 1'b1; end
      default:     begin w_hc = 1'b0; w_mc = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_hc       <= 1'b0;
      r_mc       <= 1'b0;
      r_ae       <= 1'b0;
      r_setting  <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_hc      <= w_hc;
      r_mc      <= w_mc;
      r_ae      <= w_ae;
      r_setting <= (w_next != ST_RUN);
      if (w_mode_e || w_adj_e || w_stop_e || (w_next != r_state))
        r_idle_cnt <= '0;
      else if (tick_1hz && (r_state != ST_RUN))
        r_idle_cnt <= r_idle_cnt + IW'(1);
    end
  end

`ifdef CLK_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  logic [SW-1:0] r_snz_cnt;
  logic          r_snz_act;
`endif

  // Ring control. Leaving RUN or a stop edge dominates, which also suppresses
  // a ring-start landing in the same clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ring     <= 1'b0;
      r_ring_cnt <= '0;
`ifdef CLK_SNOOZE_EN
      r_snz_cnt  <= '0;
      r_snz_act  <= 1'b0;
`endif
    end else if ((w_next != ST_RUN) || w_stop_e) begin
      r_ring    <= 1'b0;
`ifdef CLK_SNOOZE_EN
      r_snz_act <= 1'b0;
`endif
    end else if (w_ring_start) begin
      r_ring     <= 1'b1;
      r_ring_cnt <= '0;
`ifdef CLK_SNOOZE_EN
    end else if (r_ring && w_adj_e) begin
      r_ring    <= 1'b0;
      r_snz_act <= 1'b1;
      r_snz_cnt <= SW'(SNOOZE_SEC);
    end else if (r_snz_act && tick_1hz) begin
      r_snz_cnt <= r_snz_cnt - SW'(1);
      if (r_snz_cnt == SW'(1)) begin
        r_ring     <= 1'b1;
        r_ring_cnt <= '0;
        r_snz_act  <= 1'b0;
      end
`endif
    end else if (r_ring && tick_1hz) begin
      r_ring_cnt <= r_ring_cnt + RW'(1);
      if (r_ring_cnt == RW'(RING_SEC - 1))
        r_ring <= 1'b0;
    end
  end

  assign hour_change   = r_hc;
  assign minute_change = r_mc;
  assign alarm_en      = r_ae;
  assign setting       = r_setting;
  assign ring          = r_ring;
  assign state         = r_state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - scoreboard bench for clock_set_ctrl
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        key_mode = 1'b1;
  logic        key_adj = 1'b0;
  logic        key_stop = 1'b0;
  logic [20:0] count = 21'd0;
  logic [20:0] count_alarm = 21'd1;
  logic        hour_change, minute_change, alarm_en, setting, ring;
  logic [2:0]  state;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    bit          chk;
    string       tag;
    logic [7:0]  exp;
  } sb_ent_t;

  sb_ent_t sb[$];

  clock_set_ctrl #(
    .IDLE_SEC(10),
    .RING_SEC(60)
`ifdef CLK_SNOOZE_EN
    ,
    .SNOOZE_SEC(3)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .key_mode(key_mode), .key_adj(key_adj), .key_stop(key_stop),
    .count(count), .count_alarm(count_alarm),
    .hour_change(hour_change), .minute_change(minute_change), .alarm_en(alarm_en),
    .setting(setting), .ring(ring), .state(state)
  );

  always #5 clk = ~clk;

  wire [7:0] w_obs = {state, hour_change, minute_change, alarm_en, setting, ring};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Output vector {state, hour_change, minute_change, alarm_en, setting, ring}.
  function automatic logic [7:0] ev(input int st, input logic [1:0] hm, input logic ae,
                                    input logic rg);
    logic [2:0] s3;
    s3 = st[2:0];
    return {s3, hm, ae, (st != 0), rg};
  endfunction

  // One clk of stimulus; the expected result of the coming edge goes to the scoreboard.
  task automatic drive(input logic m, input logic a, input logic s, input logic t,
                       input bit c, input string tag, input logic [7:0] e);
    sb_ent_t ent;
    @(negedge clk);
    key_mode = m; key_adj = a; key_stop = s; tick_1hz = t;
    ent.chk = c; ent.tag = tag; ent.exp = e;
    sb.push_back(ent);
  endtask

  task automatic press_mode(input string tag, input logic [7:0] e);
    drive(1, 0, 0, 0, 1, tag, e);
    drive(0, 0, 0, 0, 1, tag, e);
  endtask

  // Start a ring from RUN with a matching tick, then move the time off the match.
  task automatic start_ring(input string tag);
    count = 21'd25200; count_alarm = 21'd25200;
    drive(0, 0, 0, 1, 1, tag, ev(0, 2'b00, 0, 1));
    drive(0, 0, 0, 0, 1, tag, ev(0, 2'b00, 0, 1));
    count = 21'd25201;
  endtask

  always begin
    sb_ent_t ent;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      ent = sb.pop_front();
      if (ent.chk) chk(ent.tag, {24'd0, w_obs}, {24'd0, ent.exp});
    end
  end

  localparam logic [7:0] V_RUN = 8'h00;

  initial begin
    // Reset held with key_mode pressed.
    repeat (3) @(posedge clk);
    #2;
    chk("reset_vec", {24'd0, w_obs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 1, "held_mode", V_RUN);
    drive(0, 0, 0, 0, 1, "held_mode_rel", V_RUN);

    // Mode cycling.
    press_mode("mode_1", ev(1, 2'b11, 0, 0));
    press_mode("mode_2", ev(2, 2'b11, 0, 0));
    press_mode("mode_3", ev(3, 2'b11, 1, 0));
    press_mode("mode_4", ev(4, 2'b11, 1, 0));
    press_mode("mode_0", V_RUN);

    // Adjust hold in SET_HOUR across three ticks.
    press_mode("to_set_hour", ev(1, 2'b11, 0, 0));
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 1, "adj_hour_tick", ev(1, 2'b10, 0, 0));
      drive(0, 1, 0, 0, 1, "adj_hour", ev(1, 2'b10, 0, 0));
    end
    drive(0, 0, 0, 0, 1, "adj_hour_rel", ev(1, 2'b11, 0, 0));
    press_mode("to_set_min", ev(2, 2'b11, 0, 0));
    press_mode("to_al_hour", ev(3, 2'b11, 1, 0));
    press_mode("to_al_min", ev(4, 2'b11, 1, 0));
    drive(0, 1, 0, 0, 1, "adj_al_min", ev(4, 2'b01, 1, 0));
    drive(0, 1, 0, 1, 1, "adj_al_min_tick", ev(4, 2'b01, 1, 0));
    drive(0, 0, 0, 0, 1, "adj_al_min_rel", ev(4, 2'b11, 1, 0));
    press_mode("al_min_to_run", V_RUN);

    // Idle timeout in SET_MIN on the 10th tick.
    press_mode("idle_a", ev(1, 2'b11, 0, 0));
    press_mode("idle_b", ev(2, 2'b11, 0, 0));
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 0, 1, 1, "idle_tick", (i < 10) ? ev(2, 2'b11, 0, 0) : V_RUN);
      drive(0, 0, 0, 0, 1, "idle_gap", (i < 10) ? ev(2, 2'b11, 0, 0) : V_RUN);
    end

    // Mode edge coinciding with the timeout tick wins.
    press_mode("idle2_a", ev(1, 2'b11, 0, 0));
    press_mode("idle2_b", ev(2, 2'b11, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      drive(0, 0, 0, 1, 1, "idle2_tick", ev(2, 2'b11, 0, 0));
      drive(0, 0, 0, 0, 1, "idle2_gap", ev(2, 2'b11, 0, 0));
    end
    drive(1, 0, 0, 1, 1, "idle_vs_mode", ev(3, 2'b11, 1, 0));
    drive(0, 0, 0, 0, 1, "idle_vs_mode_rel", ev(3, 2'b11, 1, 0));
    press_mode("idle2_c", ev(4, 2'b11, 1, 0));
    press_mode("idle2_run", V_RUN);

    // Ring runs for 60 ticks after the start tick.
    start_ring("ring_start");
    for (int i = 1; i <= 60; i++) begin
      drive(0, 0, 0, 1, 1, "ring_tick", ev(0, 2'b00, 0, (i < 60)));
      drive(0, 0, 0, 0, 1, "ring_gap", ev(0, 2'b00, 0, (i < 60)));
    end

    // Stop edge on the 5th tick.
    start_ring("ring2_start");
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 1, 1, "ring2_tick", ev(0, 2'b00, 0, 1));
      drive(0, 0, 0, 0, 1, "ring2_gap", ev(0, 2'b00, 0, 1));
    end
    drive(0, 0, 1, 1, 1, "ring2_stop", V_RUN);
    drive(0, 0, 0, 0, 1, "ring2_stop_rel", V_RUN);

    // Mode edge while ringing: ring drops as RUN is left.
    start_ring("ring3_start");
    press_mode("ring3_mode", ev(1, 2'b11, 0, 0));
    press_mode("ring3_b", ev(2, 2'b11, 0, 0));
    press_mode("ring3_c", ev(3, 2'b11, 1, 0));
    press_mode("ring3_d", ev(4, 2'b11, 1, 0));
    press_mode("ring3_run", V_RUN);

    // Stop edge coinciding with a ring-start.
    count = 21'd25200;
    drive(0, 0, 1, 1, 1, "stop_vs_start", V_RUN);
    count = 21'd25201;
    drive(0, 0, 0, 0, 1, "stop_vs_start_rel", V_RUN);

`ifdef CLK_SNOOZE_EN
    start_ring("snz_start");
    drive(0, 1, 0, 0, 1, "snz_adj", V_RUN);
    drive(0, 0, 0, 0, 1, "snz_adj_rel", V_RUN);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 1, 1, "snz_tick", ev(0, 2'b00, 0, (i == 3)));
      drive(0, 0, 0, 0, 1, "snz_gap", ev(0, 2'b00, 0, (i == 3)));
    end
    drive(0, 1, 0, 0, 1, "snz2_adj", V_RUN);
    drive(0, 0, 0, 0, 1, "snz2_adj_rel", V_RUN);
    drive(0, 0, 1, 0, 1, "snz2_stop", V_RUN);
    drive(0, 0, 0, 0, 1, "snz2_stop_rel", V_RUN);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 1, 1, "snz2_tick", V_RUN);
      drive(0, 0, 0, 0, 1, "snz2_gap", V_RUN);
    end
`else
    // Without snooze, key_adj does nothing while ringing.
    start_ring("adj_ring_start");
    drive(0, 1, 0, 0, 1, "adj_ring", ev(0, 2'b00, 0, 1));
    drive(0, 0, 0, 0, 1, "adj_ring_rel", ev(0, 2'b00, 0, 1));
    drive(0, 0, 1, 0, 1, "adj_ring_stop", V_RUN);
    drive(0, 0, 0, 0, 1, "adj_ring_stop_rel", V_RUN);
`endif

    // Asynchronous reset while ringing in a settled RUN.
    start_ring("rst_ring_start");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {24'd0, w_obs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("sb_drain", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
